ahb_sram_bridge: RTL and testbench

AHB_SRAM_BRIDGE -- requirements
Module: ahb_sram_bridge

---
 rtl/ahb_sram_bridge.sv | 144 ++++++++++++++
 tb/tb_ahb_sram_bridge.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_sram_bridge.sv
// AHB-Lite slave to synchronous single-port SRAM bridge.
// Reads go straight to the SRAM in the address phase. Writes are parked in a
// one-entry buffer and drained in the next cycle that has no read.
// Read-after-write hazards are resolved by byte-lane forwarding from that buffer.
module ahb_sram_bridge #(
    parameter int AW = 12
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic [31:0]   HRDATA,
    output logic          HRESP,
    input  logic [31:0]   SRAMRDATA,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS0,
    output logic [AW-1:0] SRAMADDR
);

    logic          accept;
    logic          rd_accept;
    logic          wr_accept;
    logic          drain;
    logic [AW-1:0] word_addr;
    logic [3:0]    lane_mask;

    // Address-phase state: a write waiting for its data phase, and a read
    // whose data phase is the current cycle.
    logic          wr_pend;
    logic [AW-1:0] wr_addr;
    logic [3:0]    wr_mask;
    logic          rd_phase;
    logic [AW-1:0] rd_addr;

    // One-entry write buffer.
    logic          buf_valid;
    logic [AW-1:0] buf_addr;
    logic [3:0]    buf_wen;
    logic [31:0]   buf_data;

    // Address bits beyond the array and HTRANS[0] (SEQ vs NONSEQ) carry no
    // meaning for this slave.
    logic unused_bits;
    assign unused_bits = &{1'b0, HADDR[31:AW+2], HTRANS[0]};

    // Qualifying the accept with reset keeps the SRAM port quiet while reset is held.
    assign accept    = HRESETn & HSEL & HREADY & HTRANS[1];
    assign rd_accept = accept & ~HWRITE;
    assign wr_accept = accept & HWRITE;
    assign word_addr = HADDR[AW+1:2];
    assign drain     = buf_valid & ~rd_accept;

    // Zero-wait-state slave that never signals an error.
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;

    // Byte-lane mask from transfer size and the low address bits.
    always_comb begin
        lane_mask = 4'b1111;
        case (HSIZE)
            3'd0:    lane_mask = 4'b0001 << HADDR[1:0];
            3'd1:    lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    end

    // Capture address-phase information for the following data phase.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            wr_pend  <= 1'b0;
            wr_addr  <= '0;
            wr_mask  <= '0;
            rd_phase <= 1'b0;
            rd_addr  <= '0;
        end else begin
            wr_pend  <= wr_accept;
            rd_phase <= rd_accept;
            if (wr_accept) begin
                wr_addr <= word_addr;
                wr_mask <= lane_mask;
            end
            if (rd_accept) begin
                rd_addr <= word_addr;
            end
        end
    end

    // Write buffer: refill at the end of a write data phase (overrides a drain
    // on the same edge), otherwise empty it once it has been written to the SRAM.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_wen   <= '0;
            buf_data  <= '0;
        end else if (wr_pend) begin
            buf_valid <= 1'b1;
            buf_addr  <= wr_addr;
            buf_wen   <= wr_mask;
            buf_data  <= HWDATA;
        end else if (drain) begin
            buf_valid <= 1'b0;
        end
    end

    // SRAM port arbitration: an accepted read always wins over a buffer drain.
    always_comb begin
        SRAMCS0   = 1'b0;
        SRAMWEN   = 4'b0000;
        SRAMADDR  = buf_addr;
        SRAMWDATA = buf_data;
        if (rd_accept) begin
            SRAMCS0  = 1'b1;
            SRAMADDR = word_addr;
        end else if (buf_valid) begin
            SRAMCS0 = 1'b1;
            SRAMWEN = buf_wen;
        end
    end

    // Read data: SRAM output, with lanes still held in the buffer for the same
    // word taken from the buffer instead.
    always_comb begin
        HRDATA = '0;
        if (rd_phase) begin
            HRDATA = SRAMRDATA;
            if (buf_valid && (buf_addr == rd_addr)) begin
                for (int i = 0; i < 4; i++) begin
                    if (buf_wen[i]) begin
                        HRDATA[8*i +: 8] = buf_data[8*i +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Directed testbench for ahb_sram_bridge with a behavioural synchronous SRAM.
module tb_ahb_sram_bridge;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] BUSY = 2'b01;
    localparam logic [1:0] NSEQ = 2'b10;
    localparam logic [2:0] SZ_B = 3'd0;
    localparam logic [2:0] SZ_H = 3'd1;
    localparam logic [2:0] SZ_W = 3'd2;

    logic        HCLK;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic [31:0] SRAMRDATA;
    logic [3:0]  SRAMWEN;
    logic [31:0] SRAMWDATA;
    logic        SRAMCS0;
    logic [11:0] SRAMADDR;

    int errors = 0;
    int checks = 0;

    logic [31:0] sram_mem [0:4095];
    logic [31:0] sram_merge;

    ahb_sram_bridge #(.AW(12)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP),
        .SRAMRDATA (SRAMRDATA),
        .SRAMWEN   (SRAMWEN),
        .SRAMWDATA (SRAMWDATA),
        .SRAMCS0   (SRAMCS0),
        .SRAMADDR  (SRAMADDR)
    );

    // 100 MHz clock.
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Byte-masked merge of write data into the addressed SRAM word.
    always_comb begin
        sram_merge = sram_mem[SRAMADDR];
        for (int i = 0; i < 4; i++) begin
            if (SRAMWEN[i]) sram_merge[8*i +: 8] = SRAMWDATA[8*i +: 8];
        end
    end

    // Synchronous SRAM: read data appears one cycle after the access.
    always_ff @(posedge HCLK) begin
        if (SRAMCS0) begin
            if (SRAMWEN == 4'b0000) SRAMRDATA <= sram_mem[SRAMADDR];
            else                    sram_mem[SRAMADDR] <= sram_merge;
        end
    end

    // Drive one bus cycle just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic sel, input logic rdy, input logic [1:0] trans,
                                 input logic wr, input logic [2:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata);
        @(posedge HCLK);
        #1;
        HSEL   = sel;
        HREADY = rdy;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = size;
        HADDR  = addr;
        HWDATA = wdata;
        @(negedge HCLK);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        HRESETn = 1'b0;
        HSEL    = 1'b0;
        HREADY  = 1'b1;
        HTRANS  = IDLE;
        HWRITE  = 1'b0;
        HSIZE   = SZ_W;
        HADDR   = '0;
        HWDATA  = '0;

        // Reset state
        #12;
        checkOutput("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        checkOutput("rst_hresp",     32'(HRESP),     32'd0);
        checkOutput("rst_cs",        32'(SRAMCS0),   32'd0);
        checkOutput("rst_wen",       32'(SRAMWEN),   32'd0);
        checkOutput("rst_hrdata",    HRDATA,         32'd0);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;

        // Word write 0xDEADBEEF to 0x010, drain in the cycle after the data phase
        applyStimulus(1, 1, NSEQ, 1, SZ_W, 32'h010, 32'h0);
        checkOutput("w010_aphase_cs", 32'(SRAMCS0), 32'd0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'hDEADBEEF);
        checkOutput("w010_dphase_cs", 32'(SRAMCS0), 32'd0);
        checkOutput("w010_dphase_hrdata", HRDATA, 32'd0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("w010_drain_cs",    32'(SRAMCS0),  32'd1);
        checkOutput("w010_drain_wen",   32'(SRAMWEN),  32'hF);
        checkOutput("w010_drain_addr",  32'(SRAMADDR), 32'h004);
        checkOutput("w010_drain_wdata", SRAMWDATA,     32'hDEADBEEF);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("w010_after_cs", 32'(SRAMCS0), 32'd0);

        // Read back with high address bits set; they must be ignored
        applyStimulus(1, 1, NSEQ, 0, SZ_W, 32'h8000_0010, 32'h0);
        checkOutput("r010_cs",   32'(SRAMCS0),  32'd1);
        checkOutput("r010_wen",  32'(SRAMWEN),  32'd0);
        checkOutput("r010_addr", 32'(SRAMADDR), 32'h004);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("r010_hrdata", HRDATA, 32'hDEADBEEF);

        // Ignored transfers: HSEL=0, HREADY=0 and BUSY must not touch the SRAM or buffer
        applyStimulus(0, 1, NSEQ, 1, SZ_W, 32'h010, 32'h0);
        checkOutput("nosel_cs", 32'(SRAMCS0), 32'd0);
        applyStimulus(1, 0, NSEQ, 1, SZ_W, 32'h010, 32'h77777777);
        checkOutput("nordy_cs", 32'(SRAMCS0), 32'd0);
        applyStimulus(1, 1, BUSY, 0, SZ_W, 32'h010, 32'h77777777);
        checkOutput("busy_cs", 32'(SRAMCS0), 32'd0);
        applyStimulus(1, 0, NSEQ, 0, SZ_W, 32'h010, 32'h77777777);
        checkOutput("nordy_rd_cs", 32'(SRAMCS0), 32'd0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("ignored_no_drain_cs", 32'(SRAMCS0), 32'd0);
        checkOutput("ignored_no_rdphase",  HRDATA,       32'd0);
        applyStimulus(1, 1, NSEQ, 0, SZ_W, 32'h010, 32'h0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("ignored_keep_data", HRDATA, 32'hDEADBEEF);

        // Write 0x020 immediately followed by a read of 0x020: forwarding
        applyStimulus(1, 1, NSEQ, 1, SZ_W, 32'h020, 32'h0);
        applyStimulus(1, 1, NSEQ, 0, SZ_W, 32'h020, 32'hDEADBEEF);
        checkOutput("raw020_rd_cs",   32'(SRAMCS0),  32'd1);
        checkOutput("raw020_rd_wen",  32'(SRAMWEN),  32'd0);
        checkOutput("raw020_rd_addr", 32'(SRAMADDR), 32'h008);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("raw020_hrdata",     HRDATA,        32'hDEADBEEF);
        checkOutput("raw020_drain_wen",  32'(SRAMWEN),  32'hF);
        checkOutput("raw020_drain_addr", 32'(SRAMADDR), 32'h008);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("raw020_after_cs", 32'(SRAMCS0), 32'd0);

        // 0x11223344 at 0x030, then byte 0xAA at 0x032 and read 0x030
        applyStimulus(1, 1, NSEQ, 1, SZ_W, 32'h030, 32'h0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h11223344);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("w030_drain_wen", 32'(SRAMWEN), 32'hF);
        applyStimulus(1, 1, NSEQ, 1, SZ_B, 32'h032, 32'h0);
        applyStimulus(1, 1, NSEQ, 0, SZ_W, 32'h030, 32'h55AA6677);
        checkOutput("b032_rd_addr", 32'(SRAMADDR), 32'h00C);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("b032_fwd_hrdata", HRDATA,        32'h11AA3344);
        checkOutput("b032_drain_wen",  32'(SRAMWEN),  32'h4);
        checkOutput("b032_drain_addr", 32'(SRAMADDR), 32'h00C);
        applyStimulus(1, 1, NSEQ, 0, SZ_W, 32'h030, 32'h0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("b032_sram_hrdata", HRDATA, 32'h11AA3344);

        // Halfword at 0x036 uses the upper two lanes of word 0x00D
        applyStimulus(1, 1, NSEQ, 1, SZ_H, 32'h036, 32'h0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'hBEEF0000);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("h036_drain_wen",  32'(SRAMWEN),  32'hC);
        checkOutput("h036_drain_addr", 32'(SRAMADDR), 32'h00D);

        // Write 0x040 held during ten back-to-back reads of other addresses
        applyStimulus(1, 1, NSEQ, 1, SZ_W, 32'h040, 32'h0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1, 1, NSEQ, 0, SZ_W, 32'h100 + 32'(4 * i),
                          (i == 0) ? 32'h12345678 : 32'h0);
            checkOutput($sformatf("hold040_rd%0d_wen", i), 32'(SRAMWEN), 32'd0);
        end
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("hold040_drain_wen",  32'(SRAMWEN),  32'hF);
        checkOutput("hold040_drain_addr", 32'(SRAMADDR), 32'h010);
        applyStimulus(1, 1, NSEQ, 0, SZ_W, 32'h040, 32'h0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("hold040_hrdata", HRDATA, 32'h12345678);

        // Reset while a write to 0x050 is buffered
        applyStimulus(1, 1, NSEQ, 1, SZ_W, 32'h050, 32'h0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h5A5A5A5A);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        applyStimulus(1, 1, NSEQ, 1, SZ_W, 32'h050, 32'h0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0BADF00D);
        @(posedge HCLK);
        #1;
        HWDATA = 32'h0;
        #1;
        checkOutput("rst050_pre_cs", 32'(SRAMCS0), 32'd1);
        HRESETn = 1'b0;
        #1;
        checkOutput("rst050_cs",     32'(SRAMCS0), 32'd0);
        checkOutput("rst050_wen",    32'(SRAMWEN), 32'd0);
        checkOutput("rst050_hrdata", HRDATA,       32'd0);
        @(posedge HCLK);
        @(posedge HCLK);
        #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        checkOutput("rst050_release_cs", 32'(SRAMCS0), 32'd0);
        applyStimulus(1, 1, NSEQ, 0, SZ_W, 32'h050, 32'h0);
        applyStimulus(1, 1, IDLE, 0, SZ_W, 32'h0, 32'h0);
        checkOutput("rst050_hrdata_prior", HRDATA, 32'h5A5A5A5A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
